// File: rtl/grid_scan_display.sv
// grid_scan_display: captures 8x8 generation words and scans them row by row
// onto an LED matrix with per-row dwell and anti-ghost blanking. A new image
// is swapped in only at a frame boundary so every frame shows one generation.
// Also tracks a saturating generation count plus still-life / extinct flags.
module grid_scan_display #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int GEN_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      grid_in,
  input  logic             load,
  output logic [7:0]       row_sel,
  output logic [7:0]       col_data,
  output logic             frame_done,
  output logic [GEN_W-1:0] gen_count,
  output logic             still_life,
  output logic             extinct
);

  // One counter serves both the dwell and the blank phase, so size it for the longer one.
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 32'sd1) ? $clog2(CNT_MAX) : 1;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 32'sd0);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    HAS_BLANK ? CNT_W'(BLANK_CYCLES - 32'sd1) : {CNT_W{1'b0}};

  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       row;
  logic             row_adv;
  logic             frame_boundary;

  logic [63:0]      disp;
  logic [63:0]      pend;
  logic             pend_v;
  logic [63:0]      new_img;
  logic             do_swap;

  // Scan state, dwell/blank counter and row pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHOW;
      cnt   <= {CNT_W{1'b0}};
      row   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (row_adv) begin
        row <= row + 3'd1;
      end else begin
        row <= row;
      end
    end
  end

  // Next-state logic: dwell on a row, optionally blank, then advance the row.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1'b1);
    row_adv    = 1'b0;
    case (state)
      SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_next = {CNT_W{1'b0}};
          if (HAS_BLANK) begin
            state_next = BLANK;
          end else begin
            state_next = SHOW;
            row_adv    = 1'b1;
          end
        end else begin
          state_next = SHOW;
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_next   = {CNT_W{1'b0}};
          state_next = SHOW;
          row_adv    = 1'b1;
        end else begin
          state_next = BLANK;
        end
      end
      default: begin
        state_next = SHOW;
        cnt_next   = {CNT_W{1'b0}};
      end
    endcase
    frame_boundary = row_adv && (row == 3'd7);
  end

  // Matrix drive decoded straight from registers; all lines dark while blanking.
  always_comb begin
    if (state == SHOW) begin
      row_sel  = 8'h01 << row;
      col_data = disp[{row, 3'b000} +: 8];
    end else begin
      row_sel  = 8'h00;
      col_data = 8'h00;
    end
    frame_done = frame_boundary;
  end

  // Swap source: a load landing on the boundary cycle wins over any pending image.
  always_comb begin
    if (load) begin
      new_img = grid_in;
    end else begin
      new_img = pend;
    end
    do_swap = frame_boundary && (load || pend_v);
  end

  // Image capture, frame-boundary swap and generation status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp       <= 64'h0;
      pend       <= 64'h0;
      pend_v     <= 1'b0;
      gen_count  <= {GEN_W{1'b0}};
      still_life <= 1'b0;
      extinct    <= 1'b1;
    end else if (do_swap) begin
      disp       <= new_img;
      pend_v     <= 1'b0;
      still_life <= (new_img == disp);
      extinct    <= (new_img == 64'h0);
      if (gen_count != {GEN_W{1'b1}}) begin
        gen_count <= gen_count + GEN_W'(1'b1);
      end else begin
        gen_count <= gen_count;
      end
    end else if (load && !frame_boundary) begin
      pend   <= grid_in;
      pend_v <= 1'b1;
    end else begin
      pend   <= pend;
      pend_v <= pend_v;
    end
  end

endmodule

// File: tb/tb_grid_scan_display.sv
// Self-checking bench for grid_scan_display: three instances (4/2 dwell/blank,
// 1/0 dwell/blank, and a 2-bit generation counter) checked every cycle
// against a frame-position model and a queue of expected swapped images.
module tb_grid_scan_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [63:0] grid = 64'h0;
  logic        load = 1'b0;
  logic [7:0]  row_sel, col_data;
  logic        frame_done, still_life, extinct;
  logic [15:0] gen_count;

  logic [63:0] grid1 = 64'h0;
  logic        load1 = 1'b0;
  logic [7:0]  row_sel1, col_data1;
  logic        frame_done1, still_life1, extinct1;
  logic [15:0] gen_count1;

  logic [63:0] grid2 = 64'h0;
  logic        load2 = 1'b0;
  logic [7:0]  row_sel2, col_data2;
  logic        frame_done2, still_life2, extinct2;
  logic [1:0]  gen_count2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] img;
    logic [15:0] gen;
    logic        still;
    logic        ext;
  } rec_t;
  rec_t exp_q[$];

  // bench model state
  int          t;
  logic [63:0] m_disp, m_pend;
  logic        m_pv, m_still, m_ext;
  logic [15:0] m_gen;
  logic [63:0] m1_disp, m1_pend;
  logic        m1_pv;
  logic [1:0]  m2_gen;
  logic        m2_pv;

  localparam logic [63:0] IMG_DIAG = 64'h8040_2010_0804_0201;
  localparam logic [63:0] IMG_A    = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] IMG_B    = 64'hDEAD_BEEF_0000_FFFF;
  localparam logic [63:0] IMG_C    = 64'h5A5A_5A5A_A5A5_A5A5;

  grid_scan_display #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .GEN_W(16)) u0 (
    .clk(clk), .reset(reset), .grid_in(grid), .load(load),
    .row_sel(row_sel), .col_data(col_data), .frame_done(frame_done),
    .gen_count(gen_count), .still_life(still_life), .extinct(extinct));

  grid_scan_display #(.DWELL_CYCLES(1), .BLANK_CYCLES(0), .GEN_W(16)) u1 (
    .clk(clk), .reset(reset), .grid_in(grid1), .load(load1),
    .row_sel(row_sel1), .col_data(col_data1), .frame_done(frame_done1),
    .gen_count(gen_count1), .still_life(still_life1), .extinct(extinct1));

  grid_scan_display #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .GEN_W(2)) u2 (
    .clk(clk), .reset(reset), .grid_in(grid2), .load(load2),
    .row_sel(row_sel2), .col_data(col_data2), .frame_done(frame_done2),
    .gen_count(gen_count2), .still_life(still_life2), .extinct(extinct2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  // Reset all instances for one edge; a load held during reset must be ignored.
  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b1;
    grid  = 64'hFFFF_FFFF_FFFF_FFFF;
    load1 = 1'b0;
    load2 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    load  = 1'b0;
    t = 0;
    m_disp = 64'h0; m_pend = 64'h0; m_pv = 1'b0;
    m_gen = 16'd0; m_still = 1'b0; m_ext = 1'b1;
    exp_q.delete();
    m1_disp = 64'h0; m1_pend = 64'h0; m1_pv = 1'b0;
    m2_gen = 2'd0; m2_pv = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance the model.
  task automatic cyc(input logic ld, input logic [63:0] g);
    int p, p1, r;
    logic show;
    logic [63:0] nw;
    rec_t rec;
    p  = t % 48;
    p1 = t % 8;
    load  = ld;
    grid  = g;
    load1 = (p1 == 3);
    grid1 = 64'h0102_0408_1020_4080 ^ 64'(t);
    load2 = (p == 10);
    grid2 = 64'(t) + 64'h1;
    if (p == 0 && exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      m_disp = rec.img; m_gen = rec.gen; m_still = rec.still; m_ext = rec.ext;
    end
    @(negedge clk);
    r = p / 6;
    show = (p % 6) < 4;
    chk("row_sel", {56'h0, row_sel}, show ? (64'h1 << r) : 64'h0);
    chk("col_data", {56'h0, col_data}, show ? {56'h0, m_disp[8*r +: 8]} : 64'h0);
    chk("frame_done", {63'h0, frame_done}, {63'h0, (p == 47)});
    if (p == 0) begin
      chk("gen_count", {48'h0, gen_count}, {48'h0, m_gen});
      chk("still_life", {63'h0, still_life}, {63'h0, m_still});
      chk("extinct", {63'h0, extinct}, {63'h0, m_ext});
      chk("gen_sat", {62'h0, gen_count2}, {62'h0, m2_gen});
    end
    chk("row_sel_nb", {56'h0, row_sel1}, 64'h1 << p1);
    chk("col_data_nb", {56'h0, col_data1}, {56'h0, m1_disp[8*p1 +: 8]});
    chk("frame_done_nb", {63'h0, frame_done1}, {63'h0, (p1 == 7)});
    // model of the clock edge
    if (p == 47) begin
      if (ld || m_pv) begin
        nw = ld ? g : m_pend;
        exp_q.push_back('{img: nw, gen: (m_gen == 16'hFFFF) ? m_gen : m_gen + 16'd1,
                          still: (nw == m_disp), ext: (nw == 64'h0)});
        m_pv = 1'b0;
      end
      if (load2 || m2_pv) begin
        m2_gen = (m2_gen == 2'd3) ? 2'd3 : m2_gen + 2'd1;
        m2_pv  = 1'b0;
      end
    end else begin
      if (ld) begin
        m_pend = g;
        m_pv   = 1'b1;
      end
      if (load2) m2_pv = 1'b1;
    end
    if (p1 == 7) begin
      if (load1 || m1_pv) begin
        m1_disp = load1 ? grid1 : m1_pend;
        m1_pv   = 1'b0;
      end
    end else if (load1) begin
      m1_pend = grid1;
      m1_pv   = 1'b1;
    end
    t++;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    // frame 0: blank display, diagonal loaded mid-frame
    for (int i = 0; i < 48; i++) cyc(i == 10, IMG_DIAG);
    // frame 1: diagonal shown; two loads, the second must win
    for (int i = 0; i < 48; i++) cyc(i == 5 || i == 20, (i == 5) ? 64'hFF : 64'hFF00);
    // frame 2: A pending, then B loaded on the boundary cycle bypasses it
    for (int i = 0; i < 48; i++) cyc(i == 10 || i == 47, (i == 10) ? IMG_A : IMG_B);
    // frame 3: same image again on the boundary -> still life
    for (int i = 0; i < 48; i++) cyc(i == 47, IMG_B);
    // frame 4: no load, status held across the boundary
    for (int i = 0; i < 48; i++) cyc(1'b0, 64'h0);
    // frame 5: all-zero image -> extinct
    for (int i = 0; i < 48; i++) cyc(i == 10, 64'h0);
    // frame 6: leave C pending, stop inside row 3, then reset
    for (int i = 0; i < 20; i++) cyc(i == 3, IMG_C);
    do_reset();
    // two clean frames: the dropped pending image must never appear
    for (int i = 0; i < 97; i++) cyc(1'b0, 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
